// File: rtl/lab_pkg.sv
// Shared scan defaults and index-width helpers for scan_mux and its decoder.
// Pure constants/functions: no latency, no flow control.
package lab_pkg;

    localparam int SCAN_N        = 4;
    localparam int SCAN_W        = 4;
    localparam int SCAN_PRESCALE = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r++;
        end
        return r;
    endfunction

    // A 1-entry range still needs a 1-bit field.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/scan_mux_onehot_decoder.sv
// onehot_decoder: index -> N-bit one-hot, all zeros when en_i is low.
// Combinational, no latency; no flow control.
module onehot_decoder
    import lab_pkg::*;
#(
    parameter int N = SCAN_N,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (idx_i == IDX_W'(i));
        end
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: rotates N channels, PRESCALE cycles each; data/idx/sel registered, 1-cycle data latency.
// No backpressure (en low freezes state). Define SCAN_SKIP_EN to skip channels whose ch_mask bit is 0.
module scan_mux
    import lab_pkg::*;
#(
    parameter int N        = SCAN_N,
    parameter int W        = SCAN_W,
    parameter int PRESCALE = SCAN_PRESCALE,
    localparam int IDX_W   = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N*W-1:0]   ch_data,
    input  logic [N-1:0]     ch_mask,
    output logic [W-1:0]     data_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     sel_o,
    output logic             slot_start_o
);

    localparam int PC_W = idx_w(PRESCALE);
    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [PC_W-1:0]  pcnt_q, pcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, nxt_idx;
    logic [W-1:0]     data_q, data_d;
    logic             active_q, active_d, nxt_active;
    logic             slot_start_q, slot_start_d;
    logic             advance;

`ifdef SCAN_SKIP_EN
    // Walk candidates from farthest to nearest so the nearest active one wins;
    // k = N revisits the current channel last.
    always_comb begin
        int s;
        nxt_idx    = idx_q;
        nxt_active = 1'b0;
        for (int k = N; k >= 1; k--) begin
            s = int'(idx_q) + k;
            if (s >= N) begin
                s = s - N;
            end
            if (ch_mask[s]) begin
                nxt_idx    = IDX_W'(s);
                nxt_active = 1'b1;
            end
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^ch_mask;

    always_comb begin
        nxt_idx    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        nxt_active = 1'b1;
    end
`endif

    assign advance = en && (pcnt_q == PC_LAST);

    always_comb begin
        pcnt_d       = pcnt_q;
        idx_d        = idx_q;
        active_d     = active_q;
        data_d       = data_q;
        slot_start_d = 1'b0;
        if (en) begin
            if (advance) begin
                pcnt_d       = '0;
                idx_d        = nxt_idx;
                active_d     = nxt_active;
                slot_start_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PC_W'(1);
            end
            // Sample the channel selected after this edge so data/idx/sel stay coherent.
            data_d = active_d ? ch_data[int'(idx_d)*W +: W] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            active_q     <= 1'b1;
            data_q       <= '0;
            slot_start_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            data_q       <= data_d;
            slot_start_q <= slot_start_d;
        end
    end

    onehot_decoder #(.N(N)) u_sel_dec (
        .idx_i    (idx_q),
        .en_i     (active_q),
        .onehot_o (sel_o)
    );

    assign data_o       = data_q;
    assign idx_o        = idx_q;
    assign slot_start_o = slot_start_q;

endmodule

// File: tb/tb_scan_mux.sv
// Self-checking bench for scan_mux: directed scenarios plus random en/data/reset against a slot-level model.
// Second instance covers N=3, PRESCALE=1 (non-power-of-2 wrap, advance every cycle).
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] ch_data;
    logic [3:0]  ch_mask;
    logic [3:0]  data_o;
    logic [1:0]  idx_o;
    logic [3:0]  sel_o;
    logic        slot_start_o;

    logic [11:0] ch_data3;
    logic [3:0]  data3_o;
    logic [1:0]  idx3_o;
    logic [2:0]  sel3_o;
    logic        ss3_o;

    int total = 0;
    int bad   = 0;

    // Model of the 4x4, dwell-4 scanner: which slot we're in and how far through it.
    int m_dwell, m_idx, m_data;
    bit m_act, m_ss;
    // Model of the 3-channel, dwell-1 scanner.
    int r_idx, r_data;
    bit r_ss;

    always #5 clk = ~clk;

    scan_mux dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .ch_data      (ch_data),
        .ch_mask      (ch_mask),
        .data_o       (data_o),
        .idx_o        (idx_o),
        .sel_o        (sel_o),
        .slot_start_o (slot_start_o)
    );

    scan_mux #(.N(3), .W(4), .PRESCALE(1)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .en           (1'b1),
        .ch_data      (ch_data3),
        .ch_mask      (3'b111),
        .data_o       (data3_o),
        .idx_o        (idx3_o),
        .sel_o        (sel3_o),
        .slot_start_o (ss3_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        int cand;
        bit found;
        if (rst) begin
            m_dwell = 0; m_idx = 0; m_act = 1'b1; m_data = 0; m_ss = 1'b0;
            r_idx = 0; r_data = 0; r_ss = 1'b0;
        end else begin
            if (en) begin
                if (m_dwell == 3) begin
                    m_dwell = 0;
                    m_ss    = 1'b1;
`ifdef SCAN_SKIP_EN
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        cand = (m_idx + k) % 4;
                        if (!found && ch_mask[cand]) begin
                            m_idx = cand;
                            found = 1'b1;
                        end
                    end
                    m_act = found;
`else
                    cand  = 0;
                    found = 1'b1;
                    m_idx = (m_idx + 1) % 4;
                    m_act = found;
`endif
                end else begin
                    m_dwell++;
                    m_ss = 1'b0;
                end
                m_data = m_act ? int'((ch_data >> (4 * m_idx)) & 16'hF) : 0;
            end else begin
                m_ss = 1'b0;
            end
            r_idx  = (r_idx + 1) % 3;
            r_ss   = 1'b1;
            r_data = int'((ch_data3 >> (4 * r_idx)) & 12'hF);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("data", 32'(data_o), m_data);
        check("idx", 32'(idx_o), m_idx);
        check("sel", 32'(sel_o), m_act ? (1 << m_idx) : 0);
        check("slot_start", 32'(slot_start_o), 32'(m_ss));
        check("n3_data", 32'(data3_o), r_data);
        check("n3_idx", 32'(idx3_o), r_idx);
        check("n3_sel", 32'(sel3_o), 1 << r_idx);
        check("n3_slot_start", 32'(ss3_o), 32'(r_ss));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; ch_data = 16'hDCBA; ch_mask = 4'hF; ch_data3 = 12'h987;
        step();
        check("rst_idx", 32'(idx_o), 0);
        check("rst_sel", 32'(sel_o), 1);
        check("rst_data", 32'(data_o), 0);
        check("rst_ss", 32'(slot_start_o), 0);

        // Basic scan: channel 0 shows A, then B with a slot_start pulse.
        rst = 1'b0; en = 1'b1;
        step();
        check("first_data", 32'(data_o), 'hA);
        check("first_ss", 32'(slot_start_o), 0);
        repeat (3) step();
        check("ch1_data", 32'(data_o), 'hB);
        check("ch1_sel", 32'(sel_o), 4'b0010);
        check("ch1_ss", 32'(slot_start_o), 1);

        // Freeze at pcnt=2 of channel 1, then resume for the remaining cycle.
        repeat (2) step();
        en = 1'b0;
        repeat (5) step();
        check("hold_idx", 32'(idx_o), 1);
        check("hold_ss", 32'(slot_start_o), 0);
        en = 1'b1;
        step();
        check("resume_idx", 32'(idx_o), 1);
        step();
        check("resume_adv_idx", 32'(idx_o), 2);
        check("resume_adv_data", 32'(data_o), 'hC);
        step();

        // Mid-slot reset on channel 2 restarts at channel 0 with a full dwell.
        rst = 1'b1;
        step();
        check("midrst_idx", 32'(idx_o), 0);
        check("midrst_sel", 32'(sel_o), 1);
        check("midrst_data", 32'(data_o), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("dwell0_idx", 32'(idx_o), 0);
        end
        step();
        check("dwell0_end_idx", 32'(idx_o), 1);

        // Live data change on the selected channel shows one edge later.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ch_data[3:0] = 4'h5;
        step();
        check("live_data", 32'(data_o), 'h5);

        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            rst      = ($urandom_range(0, 49) == 0);
            ch_data  = 16'($urandom);
            ch_mask  = 4'($urandom);
            ch_data3 = 12'($urandom);
            step();
        end

`ifdef SCAN_SKIP_EN
        rst = 1'b1; en = 1'b1; ch_mask = 4'b0101; ch_data = 16'hDCBA;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("skip_idx2", 32'(idx_o), 2);
        repeat (4) step();
        check("skip_idx0", 32'(idx_o), 0);
        repeat (4) step();
        check("skip_idx2b", 32'(idx_o), 2);
        ch_mask = 4'b0000;
        repeat (4) step();
        check("allmask_sel", 32'(sel_o), 0);
        check("allmask_data", 32'(data_o), 0);
        check("allmask_ss", 32'(slot_start_o), 1);
        ch_mask = 4'b1000;
        repeat (4) step();
        check("unmask_idx", 32'(idx_o), 3);
        check("unmask_sel", 32'(sel_o), 4'b1000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
